// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for uart_rx: enable/read handshake, FWFT byte FIFO, parity recovery, sticky errors.
// Optional frame/error statistics counters are built when UART_RX_STATS_EN is defined.
module uart_rx_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_en,
    input  logic          pop,
    input  logic          err_clr,
    input  logic          rx_ok,
    input  logic [7:0]    rxd_out,
    input  logic          parity_error,
    output logic          rx_en,
    output logic          rd_data_flag,
    output logic [7:0]    rdata,
    output logic          rvalid,
    output logic          fifo_full,
    output logic [AW:0]   fifo_level,
    output logic          ovr_err,
    output logic          par_err,
    output logic [15:0]   frame_cnt,
    output logic [7:0]    err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RECOVER = 2'd2
    } state_e;

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    state_e          state_q, state_d;
    logic            rec_cnt_q, rec_cnt_d;
    logic            rx_en_q, rdf_q;
    logic            rx_ok_q, perr_q;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q, level_d;
    logic            ovr_err_q, par_err_q;

    logic            in_run;
    logic            ok_rise;
    logic            par_rise;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            overrun;

    assign in_run   = (state_q == S_RUN);
    assign ok_rise  = rx_ok & ~rx_ok_q & in_run;
    assign par_rise = parity_error & ~perr_q & in_run;
    assign full     = (level_q == FULL_LVL);
    assign do_pop   = pop & (level_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push  = ok_rise & (~full | do_pop);
    assign overrun  = ok_rise & full & ~pop;

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (host_en) state_d = S_RUN;
            end
            S_RUN: begin
                if (!host_en)     state_d = S_IDLE;
                else if (par_rise) state_d = S_RECOVER;
            end
            S_RECOVER: begin
                rec_cnt_d = 1'b1;
                if (rec_cnt_q) begin
                    rec_cnt_d = 1'b0;
                    state_d   = host_en ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rec_cnt_q <= 1'b0;
            rx_en_q   <= 1'b0;
            rdf_q     <= 1'b0;
            rx_ok_q   <= 1'b0;
            perr_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovr_err_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
            // Outputs decoded from the next state so they are plain flops.
            rx_en_q   <= (state_d == S_RUN);
            rdf_q     <= (state_d == S_RUN);
            rx_ok_q   <= rx_ok;
            perr_q    <= parity_error;
            level_q   <= level_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (overrun)      ovr_err_q <= 1'b1;
            else if (err_clr) ovr_err_q <= 1'b0;
            if (par_rise)     par_err_q <= 1'b1;
            else if (err_clr) par_err_q <= 1'b0;
        end
    end

    // Storage needs no reset: the head is masked by rvalid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= rxd_out;
    end

`ifdef UART_RX_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;
    logic        err_event;

    assign err_event = overrun | par_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (ok_rise)      frame_cnt_q <= frame_cnt_q + 16'd1;
            else if (err_clr) frame_cnt_q <= '0;
            if (err_event) begin
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (err_clr) begin
                err_cnt_q <= '0;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

    assign rx_en        = rx_en_q;
    assign rd_data_flag = rdf_q;
    assign rvalid       = (level_q != '0);
    assign rdata        = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_full    = full;
    assign fifo_level   = level_q;
    assign ovr_err      = ovr_err_q;
    assign par_err      = par_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (DEPTH=4): handshake, FIFO, overrun, parity recovery, flags, reset.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, host_en, pop, err_clr, rx_ok, parity_error;
    logic [7:0]  rxd_out;
    logic        rx_en, rd_data_flag, rvalid, fifo_full, ovr_err, par_err;
    logic [7:0]  rdata, err_cnt;
    logic [2:0]  fifo_level;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_err    = 0;

    uart_rx_ctrl #(.DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_en      (host_en),
        .pop          (pop),
        .err_clr      (err_clr),
        .rx_ok        (rx_ok),
        .rxd_out      (rxd_out),
        .parity_error (parity_error),
        .rx_en        (rx_en),
        .rd_data_flag (rd_data_flag),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .fifo_full    (fifo_full),
        .fifo_level   (fifo_level),
        .ovr_err      (ovr_err),
        .par_err      (par_err),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rxd_out = b;
        rx_ok   = 1'b1;
        step();
        rx_ok   = 1'b0;
        step();
    endtask

    task automatic pop_one();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rx_en"}, 16'(rx_en), 16'h0);
        chk({tag, ".rdf"},   16'(rd_data_flag), 16'h0);
        chk({tag, ".rvalid"}, 16'(rvalid), 16'h0);
        chk({tag, ".full"},  16'(fifo_full), 16'h0);
        chk({tag, ".level"}, 16'(fifo_level), 16'h0);
        chk({tag, ".rdata"}, 16'(rdata), 16'h00);
        chk({tag, ".ovr"},   16'(ovr_err), 16'h0);
        chk({tag, ".par"},   16'(par_err), 16'h0);
        chk({tag, ".frame"}, frame_cnt, 16'h0);
        chk({tag, ".errcnt"}, 16'(err_cnt), 16'h0);
    endtask

    initial begin
        rst_n = 1'b0; host_en = 1'b0; pop = 1'b0; err_clr = 1'b0;
        rx_ok = 1'b0; parity_error = 1'b0; rxd_out = 8'h00;
        step(); step();
        chk_reset_vals("reset");

        // Enable: outputs follow one cycle later.
        rst_n = 1'b1; host_en = 1'b1;
        step();
        chk("en.rx_en", 16'(rx_en), 16'h1);
        chk("en.rdf",   16'(rd_data_flag), 16'h1);

        // rx_ok held 5 cycles -> exactly one push.
        rxd_out = 8'hA5; rx_ok = 1'b1;
        step();
        chk("cap.rvalid", 16'(rvalid), 16'h1);
        chk("cap.rdata",  16'(rdata), 16'hA5);
        step(); step(); step(); step();
        rx_ok = 1'b0;
        step();
        chk("cap.level_single", 16'(fifo_level), 16'h1);
        pop_one();
        chk("cap.popped_level", 16'(fifo_level), 16'h0);
        chk("cap.empty_rdata",  16'(rdata), 16'h00);

        // Five frames into a 4-deep FIFO: last one dropped.
        for (int i = 1; i <= 5; i++) send(8'(i));
        chk("ovr.full",  16'(fifo_full), 16'h1);
        chk("ovr.level", 16'(fifo_level), 16'h4);
        chk("ovr.flag",  16'(ovr_err), 16'h1);
`ifdef UART_RX_STATS_EN
        chk("ovr.frame_cnt", frame_cnt, 16'd6);
        chk("ovr.err_cnt",   16'(err_cnt), 16'd1);
`endif
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr.pop%0d", i), 16'(rdata), 16'(i));
            pop_one();
        end
        chk("ovr.drained_rvalid", 16'(rvalid), 16'h0);
        pop_one();
        chk("ovr.empty_pop_level", 16'(fifo_level), 16'h0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovr.cleared", 16'(ovr_err), 16'h0);

        // Full FIFO: push and pop together -> no overrun, level held.
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
        chk("fullpp.pre_level", 16'(fifo_level), 16'h4);
        rxd_out = 8'h15; rx_ok = 1'b1; pop = 1'b1;
        step();
        rx_ok = 1'b0; pop = 1'b0;
        chk("fullpp.ovr",   16'(ovr_err), 16'h0);
        chk("fullpp.level", 16'(fifo_level), 16'h4);
        chk("fullpp.head",  16'(rdata), 16'h12);
        pop_one(); pop_one(); pop_one();
        chk("fullpp.tail",  16'(rdata), 16'h15);
        chk("fullpp.level1", 16'(fifo_level), 16'h1);
        pop_one();
`ifdef UART_RX_STATS_EN
        chk("fullpp.frame_cnt", frame_cnt, 16'd5);
        chk("fullpp.err_cnt",   16'(err_cnt), 16'd0);
`endif

        // Parity rise: rx_en low for exactly two cycles.
        parity_error = 1'b1;
        step();
        chk("par.rx_en_c1", 16'(rx_en), 16'h0);
        chk("par.flag",     16'(par_err), 16'h1);
        parity_error = 1'b0;
        step();
        chk("par.rx_en_c2", 16'(rx_en), 16'h0);
        step();
        chk("par.rx_en_c3", 16'(rx_en), 16'h1);
        chk("par.rdf_c3",   16'(rd_data_flag), 16'h1);
`ifdef UART_RX_STATS_EN
        chk("par.err_cnt", 16'(err_cnt), 16'd1);
`endif
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("par.cleared", 16'(par_err), 16'h0);

        // Second parity rise coincident with err_clr: set wins.
        parity_error = 1'b1; err_clr = 1'b1;
        step();
        parity_error = 1'b0; err_clr = 1'b0;
        chk("par.set_wins", 16'(par_err), 16'h1);
`ifdef UART_RX_STATS_EN
        chk("par.cnt_inc_wins", 16'(err_cnt), 16'd1);
`endif
        step(); step();
        chk("par.recovered", 16'(rx_en), 16'h1);

        // Two bytes queued, then host disables.
        send(8'h21); send(8'h22);
`ifdef UART_RX_STATS_EN
        chk("stats.frame_cnt", frame_cnt, 16'd2);
`else
        chk("stats.frame_tied", frame_cnt, 16'h0);
        chk("stats.err_tied",   16'(err_cnt), 16'h0);
`endif
        host_en = 1'b0;
        step();
        chk("dis.rx_en", 16'(rx_en), 16'h0);
        chk("dis.rdf",   16'(rd_data_flag), 16'h0);
        chk("dis.level", 16'(fifo_level), 16'h2);
        send(8'h33);
        chk("dis.no_push", 16'(fifo_level), 16'h2);
        chk("dis.head",    16'(rdata), 16'h21);

        // One-cycle synchronous reset clears everything.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset_vals("rst2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
